// File: rtl/rng_arb_pkg.sv
// Shared types and widths for the RNG share arbiter.
//   state_t : arbiter FSM states
//   RNG_W   : width of the random value
//   PTR_W   : round-robin pointer / grant index width (covers up to 8 channels)
//   CNT_W   : wait counter width (covers LAT up to 4)
//   RETRY_W : re-roll counter width
package rng_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DELIVER
    } state_t;

    localparam int RNG_W   = 4;
    localparam int PTR_W   = 3;
    localparam int CNT_W   = 3;
    localparam int RETRY_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : channel with highest priority this round
//   gnt : one-hot grant of the first requester at/after ptr, wrapping
//   any : at least one request present
module rr_pick
    import rng_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic             any
);

    // Scan offsets 0..NREQ-1 from ptr; the first live requester wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!any && k == (int'(ptr) + i) % NREQ && req[k]) begin
                    gnt[k] = 1'b1;
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rng_share_arbiter.sv
// Shares one 4-bit LFSR among NREQ channels: round-robin grant, one-cycle
// LFSR step strobe, LAT-cycle settle wait, then valid/ack delivery of the
// sampled value to the granted channel.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req  : level request per channel, held until ack or abandon
//   i_ack  : per-channel accept of the delivered value
//   i_lfsr : current LFSR output
//   o_step : one-cycle LFSR advance strobe
//   o_gnt  : one-hot grant, held for the whole transaction
//   o_valid, o_data : delivered value for the granted channel
//   o_busy : a transaction is in flight
// Optional feature macro: RNG_ARB_NO_REPEAT_EN -- re-roll (up to MAX_RETRY
// times) when the sample equals the last value delivered to that channel.
module rng_share_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int LAT       = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_ack,
    input  logic [RNG_W-1:0] i_lfsr,
    output logic             o_step,
    output logic [NREQ-1:0]  o_gnt,
    output logic             o_valid,
    output logic [RNG_W-1:0] o_data,
    output logic             o_busy
);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic [NREQ-1:0]    pick_gnt;
    logic               pick_any;
    logic               req_g;
    logic               ack_g;
    logic               repeat_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (i_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) pick_idx = PTR_W'(i);
        end
    end

    assign req_g    = |(i_req & o_gnt);
    assign ack_g    = |(i_ack & o_gnt);
    assign ptr_next = (int'(gidx) == NREQ - 1) ? '0 : gidx + PTR_W'(1);
    assign o_busy   = (state != S_IDLE);

`ifdef RNG_ARB_NO_REPEAT_EN
    logic [NREQ-1:0][RNG_W-1:0] last;

    always_comb begin
        repeat_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(gidx) == i && i_lfsr == last[i]) repeat_hit = 1'b1;
        end
    end

    // Only a completed delivery (ack) counts as "last delivered".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last <= '0;
        end else if (state == S_DELIVER && ack_g) begin
            for (int i = 0; i < NREQ; i++) begin
                if (int'(gidx) == i) last[i] <= o_data;
            end
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            gidx    <= '0;
            cnt     <= '0;
            retry   <= '0;
            o_step  <= 1'b0;
            o_gnt   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_step <= 1'b0;
            // Ack completes a delivery even if the request drops in the same
            // cycle; otherwise a dropped request abandons the transaction.
            // Either way the pointer moves past the granted channel.
            if (state != S_IDLE && ((state == S_DELIVER && ack_g) || !req_g)) begin
                o_gnt   <= '0;
                o_valid <= 1'b0;
                ptr     <= ptr_next;
                state   <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pick_any) begin
                            o_gnt  <= pick_gnt;
                            gidx   <= pick_idx;
                            retry  <= '0;
                            o_step <= 1'b1;
                            state  <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        cnt   <= CNT_W'(LAT);
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (cnt == CNT_W'(1)) begin
                            if (repeat_hit && int'(retry) < MAX_RETRY) begin
                                retry  <= retry + RETRY_W'(1);
                                o_step <= 1'b1;
                                state  <= S_STEP;
                            end else begin
                                o_data  <= i_lfsr;
                                o_valid <= 1'b1;
                                state   <= S_DELIVER;
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: ; // S_DELIVER: hold until ack or abandon
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Bench for rng_share_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random
// request/ack/abandon traffic. Honors RNG_ARB_NO_REPEAT_EN if defined.
module tb_rng_share_arbiter;
    import rng_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int LAT = 1;
    localparam int LAT_B = 3;
    localparam int MAX_RETRY = 3;
`ifdef RNG_ARB_NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0] req = '0, ack = '0, b_req = '0, b_ack = '0;
    logic [3:0] lfsr = '0;
    logic a_step, a_valid, a_busy, b_step, b_valid, b_busy;
    logic [NREQ-1:0] a_gnt, b_gnt;
    logic [3:0] a_data, b_data;

    always #5 clk = ~clk;

    rng_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAX_RETRY(MAX_RETRY)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_ack(ack), .i_lfsr(lfsr),
        .o_step(a_step), .o_gnt(a_gnt), .o_valid(a_valid), .o_data(a_data), .o_busy(a_busy));

    rng_share_arbiter #(.NREQ(NREQ), .LAT(LAT_B), .MAX_RETRY(MAX_RETRY)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_ack(b_ack), .i_lfsr(lfsr),
        .o_step(b_step), .o_gnt(b_gnt), .o_valid(b_valid), .o_data(b_data), .o_busy(b_busy));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    bit lfsr_rand = 1'b0;
    logic [3:0] lq[$];

    // Reference model (for dut_a): one transaction at a time, described by
    // the granted channel, the cycle of its latest step strobe and the value
    // being delivered.
    bit m_busy, m_valid;
    int m_g, m_step_at, m_ptr, m_retry;
    logic [3:0] m_data;
    logic [3:0] m_last[NREQ];

    always @(posedge clk) begin
        int c;
        c = cyc;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_g = 0; m_step_at = -1; m_ptr = 0;
            m_retry = 0; m_data = '0;
            for (int i = 0; i < NREQ; i++) m_last[i] = '0;
        end else if (!m_busy) begin
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (!m_busy && req[k]) begin
                    m_busy = 1; m_g = k; m_step_at = c + 1; m_retry = 0; m_valid = 0;
                end
            end
        end else if (m_valid && ack[m_g]) begin
            m_last[m_g] = m_data;
            m_ptr = (m_g + 1) % NREQ;
            m_busy = 0; m_valid = 0;
        end else if (!req[m_g]) begin
            m_ptr = (m_g + 1) % NREQ;
            m_busy = 0; m_valid = 0;
        end else if (!m_valid && c == m_step_at + LAT) begin
            if (NOREP && lfsr == m_last[m_g] && m_retry < MAX_RETRY) begin
                m_retry = m_retry + 1;
                m_step_at = c + 1;
            end else begin
                m_valid = 1;
                m_data = lfsr;
            end
        end
    end

    // Per-cycle compare of dut_a against the model.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        logic es, ev, eb;
        logic [3:0] ed;
        if (chk_on) begin
            eg = '0; es = 0; ev = 0; eb = 0; ed = '0;
            if (rst_n) begin
                eb = m_busy;
                if (m_busy) eg[m_g] = 1'b1;
                es = m_busy && (m_step_at == cyc);
                ev = m_valid;
                ed = m_data;
            end
            n_cmp++;
            if (a_step !== es || a_gnt !== eg || a_valid !== ev || a_busy !== eb ||
                ((ev || !rst_n) && a_data !== ed)) begin
                n_err++;
                $display("FAIL cycle_model cyc=%0d got step=%b gnt=%b valid=%b data=%0d busy=%b want step=%b gnt=%b valid=%b data=%0d busy=%b",
                         cyc, a_step, a_gnt, a_valid, a_data, a_busy, es, eg, ev, ed, eb);
            end
        end
    end

    // LFSR stand-in: next queued value appears after each dut_a step strobe.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (a_step && lq.size() > 0) lfsr = lq.pop_front();
            else if (lfsr_rand) lfsr = 4'($urandom);
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Waits for dut_a o_valid; dt counts cycles from the current one.
    task automatic wait_valid(output int dt, output int steps, output int sdt);
        dt = 0; steps = 0; sdt = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dt++;
            if (a_step) begin
                steps++;
                if (sdt < 0) sdt = dt;
            end
            if (a_valid) break;
        end
        #1;
        if (!a_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic do_ack_a(input logic [NREQ-1:0] a, input logic [NREQ-1:0] req_after);
        ack = a; req = req_after;
        tick();
        ack = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; req = '0; ack = '0; b_req = '0; b_ack = '0;
        tick(); tick();
        rst_n = 1;
    endtask

    initial begin
        int dt, st, sdt;
        @(posedge clk); #1;
        chk_on = 1;
        do_reset();

        // reset state
        chk("rst_step", a_step, 0);
        chk("rst_gnt", a_gnt, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_busy", a_busy, 0);

        // 1: single request, latency and data
        lq.push_back(4'd9);
        req = 2'b01;
        wait_valid(dt, st, sdt);
        chk("t1_step_lat", sdt, 1);
        chk("t1_valid_lat", dt, 3);
        chk("t1_data", a_data, 9);
        chk("t1_gnt", a_gnt, 1);
        do_ack_a(2'b01, 2'b00);
        chk("t1_busy_after_ack", a_busy, 0);

        // 2: both held, grants alternate, one step each
        do_reset();
        for (int v = 1; v <= 4; v++) lq.push_back(4'(v));
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_valid(dt, st, sdt);
            chk("t2_gnt", a_gnt, (t % 2 == 0) ? 1 : 2);
            chk("t2_steps", st, 1);
            do_ack_a(a_gnt, 2'b11);
        end
        req = 2'b00;
        tick();

        // 3: ch1 abandons during WAIT; next grant to ch0
        req = 2'b10;
        for (int i = 0; i < 10 && !a_step; i++) tick();
        chk("t3_gnt", a_gnt, 2);
        tick();
        req = 2'b00;
        tick();
        chk("t3_busy", a_busy, 0);
        chk("t3_valid", a_valid, 0);
        req = 2'b11;
        wait_valid(dt, st, sdt);
        chk("t3_next_gnt", a_gnt, 1);
        do_ack_a(2'b01, 2'b00);

        // 4: reset during DELIVER
        lq.push_back(4'd5);
        req = 2'b01;
        wait_valid(dt, st, sdt);
        chk("t4_data", a_data, 5);
        rst_n = 0; req = 2'b11;
        #1;
        chk("t4_rst_valid", a_valid, 0);
        chk("t4_rst_gnt", a_gnt, 0);
        chk("t4_rst_data", a_data, 0);
        chk("t4_rst_busy", a_busy, 0);
        tick();
        rst_n = 1;
        wait_valid(dt, st, sdt);
        chk("t4_post_gnt", a_gnt, 1);
        do_ack_a(2'b01, 2'b00);

        // 6: LAT=3 instance, stray ack on ch1 ignored
        do_reset();
        lfsr = 4'd6;
        b_ack = 2'b10;
        b_req = 2'b01;
        dt = 0;
        for (int i = 0; i < 40 && !b_valid; i++) begin
            @(negedge clk); dt++; #1;
        end
        chk("t6_valid_lat", dt, 5);
        chk("t6_gnt", b_gnt, 1);
        chk("t6_data", b_data, 6);
        b_ack = 2'b01; b_req = 2'b00;
        tick();
        b_ack = '0;
        chk("t6_busy_after_ack", b_busy, 0);

`ifdef RNG_ARB_NO_REPEAT_EN
        // 5: repeat suppression
        do_reset();
        lq.push_back(4'd7);
        req = 2'b01;
        wait_valid(dt, st, sdt);
        chk("t5_seed_data", a_data, 7);
        do_ack_a(2'b01, 2'b00);
        lq.push_back(4'd7); lq.push_back(4'd7); lq.push_back(4'd3);
        req = 2'b01;
        wait_valid(dt, st, sdt);
        chk("t5a_steps", st, 3);
        chk("t5a_data", a_data, 3);
        do_ack_a(2'b01, 2'b00);
        lq.push_back(4'd7);
        req = 2'b01;
        wait_valid(dt, st, sdt);
        do_ack_a(2'b01, 2'b00);
        for (int i = 0; i < 4; i++) lq.push_back(4'd7);
        req = 2'b01;
        wait_valid(dt, st, sdt);
        chk("t5b_steps", st, 4);
        chk("t5b_data", a_data, 7);
        do_ack_a(2'b01, 2'b00);
`endif

        // random traffic
        do_reset();
        lq.delete();
        lfsr_rand = 1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            ack = '0;
            for (int ch = 0; ch < NREQ; ch++) begin
                if (req[ch] && a_gnt[ch] && a_valid && $urandom_range(0, 1) == 1) begin
                    ack[ch] = 1'b1;
                    if ($urandom_range(0, 1) == 1) req[ch] = 1'b0;
                end else if (req[ch] && a_gnt[ch] && $urandom_range(0, 19) == 0) begin
                    req[ch] = 1'b0;
                end else if (!req[ch] && $urandom_range(0, 3) == 0) begin
                    req[ch] = 1'b1;
                end
                if (!ack[ch] && $urandom_range(0, 9) == 0 && !(a_gnt[ch] && a_valid)) ack[ch] = 1'b1;
            end
            if (n == 1500) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end
        end
        req = '0; ack = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
